// File: rtl/hazard_unit_if.sv
// Signal bundle between the pipeline datapath and hazard_unit.
// The master drives the hazard sources. The slave returns stall, flush and freeze controls.
interface hazard_unit_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_is_load;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_stall;
  logic        ifid_stall;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        pipe_freeze;
  logic [4:0]  fwd_rd;
  logic        mem_timeout;
  logic [15:0] stall_cycles;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_reg_write,
           ex_is_load, branch_taken, mem_req, mem_ready,
    input  pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze,
           fwd_rd, mem_timeout, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_reg_write,
           ex_is_load, branch_taken, mem_req, mem_ready,
    output pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze,
           fwd_rd, mem_timeout, stall_cycles
  );
endinterface

// File: rtl/hazard_unit.sv
// Load-use / taken-branch / memory-wait hazard controller for the five-stage core.
// Defining HAZARD_PERF_CNT_EN enables the saturating stall_cycles performance counter.
module hazard_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  hazard_unit_if.slave hz
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t     state_reg, state_next;
  logic       flush_pend_reg, flush_pend_next;
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic       mem_timeout_reg, mem_timeout_next;

  logic       freeze_raw;
  logic       freeze;
  logic       flush;
  logic       lu;
  logic       lu_stall;
  logic       pc_stall;

  // One comparator per source operand of the ID instruction.
  logic [4:0] src_rs [2];
  logic [1:0] src_use;
  logic [1:0] src_hit;

  assign src_rs[0]  = hz.id_rs1;
  assign src_rs[1]  = hz.id_rs2;
  assign src_use[0] = hz.id_use_rs1;
  assign src_use[1] = hz.id_use_rs2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_use[gi] & (src_rs[gi] == hz.ex_rd);
    end
  endgenerate

  assign lu = hz.ex_is_load & hz.ex_reg_write & (hz.ex_rd != 5'd0) & (|src_hit);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= RUN;
      flush_pend_reg  <= 1'b0;
      wait_cnt_reg    <= 8'd0;
      mem_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      flush_pend_reg  <= flush_pend_next;
      wait_cnt_reg    <= wait_cnt_next;
      mem_timeout_reg <= mem_timeout_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    flush_pend_next  = flush_pend_reg;
    wait_cnt_next    = wait_cnt_reg;
    mem_timeout_next = mem_timeout_reg;
    freeze_raw       = 1'b0;

    case (state_reg)
      RUN: begin
        wait_cnt_next = 8'd0;
        freeze_raw    = hz.mem_req & ~hz.mem_ready;
        if (freeze_raw) state_next = MEM_WAIT;
      end
      MEM_WAIT: begin
        freeze_raw = ~hz.mem_ready;
        if (wait_cnt_reg != 8'hFF) wait_cnt_next = wait_cnt_reg + 8'd1;
        // Flag only; the freeze is held until memory actually answers.
        if (wait_cnt_reg == TIMEOUT_CNT) mem_timeout_next = 1'b1;
        if (hz.mem_ready) state_next = RUN;
      end
    endcase

    // Reset outranks every hazard, so nothing is asserted while it is held.
    freeze   = freeze_raw & ~reset;
    flush    = ~reset & ~freeze & (hz.branch_taken | flush_pend_reg);
    lu_stall = ~reset & lu & ~freeze & ~flush;

    // A branch resolved during a freeze is remembered and squashed on release.
    if (freeze && hz.branch_taken) flush_pend_next = 1'b1;
    else if (flush)                flush_pend_next = 1'b0;
  end

  assign pc_stall        = freeze | lu_stall;
  assign hz.pc_stall     = pc_stall;
  assign hz.ifid_stall   = pc_stall;
  assign hz.ifid_flush   = flush;
  assign hz.idex_bubble  = flush | lu_stall;
  assign hz.pipe_freeze  = freeze;
  assign hz.fwd_rd       = hz.ex_reg_write ? hz.ex_rd : 5'd0;
  assign hz.mem_timeout  = mem_timeout_reg;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cycles_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_reg <= 16'd0;
    end else if ((pc_stall | flush) && (stall_cycles_reg != 16'hFFFF)) begin
      stall_cycles_reg <= stall_cycles_reg + 16'd1;
    end
  end

  assign hz.stall_cycles = stall_cycles_reg;
`else
  assign hz.stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: vector table plus multi-cycle sequences,
// with expected outputs queued at drive time and popped when sampled.
module tb_hazard_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_unit_if hz ();

  hazard_unit #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [15:0] PERF_EXP = 16'd5;
`else
  localparam logic [15:0] PERF_EXP = 16'd0;
`endif

  // Packed as {pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze, mem_timeout, fwd_rd}.
  typedef struct {
    string       nm;
    logic [10:0] v;
  } sb_t;

  typedef struct {
    string       nm;
    logic [9:0]  rs;   // {rs1, rs2}
    logic [1:0]  usr;  // {use_rs1, use_rs2}
    logic [4:0]  rd;
    logic [4:0]  ctl;  // {reg_write, is_load, branch_taken, mem_req, mem_ready}
    logic [10:0] e;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vt[10];
  int   n_checks = 0;
  int   n_fail   = 0;

  // flags = {pc_stall, ifid_flush, idex_bubble, pipe_freeze, mem_timeout}
  function automatic logic [10:0] ex(input logic [4:0] f, input logic [4:0] fwd);
    return {f[4], f[4], f[3], f[2], f[1], f[0], fwd};
  endfunction

  task automatic drive(input logic [9:0] rs, input logic [1:0] usr,
                       input logic [4:0] rd, input logic [4:0] ctl);
    hz.id_rs1       = rs[9:5];
    hz.id_rs2       = rs[4:0];
    hz.id_use_rs1   = usr[1];
    hz.id_use_rs2   = usr[0];
    hz.ex_rd        = rd;
    hz.ex_reg_write = ctl[4];
    hz.ex_is_load   = ctl[3];
    hz.branch_taken = ctl[2];
    hz.mem_req      = ctl[1];
    hz.mem_ready    = ctl[0];
  endtask

  task automatic idle();
    drive(10'd0, 2'b00, 5'd0, 5'b00000);
  endtask

  // Called at posedge+1 with inputs already driven; samples mid-cycle, returns at next posedge+1.
  task automatic cyc(input string nm, input logic [10:0] e);
    sb_t         s;
    logic [10:0] act;
    s.nm = nm;
    s.v  = e;
    sb_q.push_back(s);
    #3;
    s   = sb_q.pop_front();
    act = {hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.idex_bubble,
           hz.pipe_freeze, hz.mem_timeout, hz.fwd_rd};
    n_checks++;
    if (act !== s.v) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", s.nm, act, s.v);
    end else begin
      $display("ok   %s: %b", s.nm, act);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string nm, input logic [15:0] req);
    n_checks++;
    if (hz.stall_cycles !== req) begin
      n_fail++;
      $display("FAIL %s: stall_cycles got %0d required %0d", nm, hz.stall_cycles, req);
    end else begin
      $display("ok   %s: stall_cycles %0d", nm, hz.stall_cycles);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Single-cycle combinational cases, each starting from RUN with nothing pending.
    vt[0] = '{"lu_rs1",        {5'd5, 5'd0}, 2'b10, 5'd5, 5'b11000, ex(5'b10100, 5'd5)};
    vt[1] = '{"lu_rd0",        {5'd0, 5'd0}, 2'b10, 5'd0, 5'b11000, ex(5'b00000, 5'd0)};
    vt[2] = '{"lu_no_use",     {5'd5, 5'd0}, 2'b00, 5'd5, 5'b11000, ex(5'b00000, 5'd5)};
    vt[3] = '{"lu_rs2",        {5'd1, 5'd9}, 2'b01, 5'd9, 5'b11000, ex(5'b10100, 5'd9)};
    vt[4] = '{"not_load",      {5'd5, 5'd0}, 2'b10, 5'd5, 5'b10000, ex(5'b00000, 5'd5)};
    vt[5] = '{"load_no_write", {5'd5, 5'd0}, 2'b10, 5'd5, 5'b01000, ex(5'b00000, 5'd0)};
    vt[6] = '{"branch",        {5'd0, 5'd0}, 2'b00, 5'd3, 5'b10100, ex(5'b01100, 5'd3)};
    vt[7] = '{"branch_lu",     {5'd7, 5'd0}, 2'b10, 5'd7, 5'b11100, ex(5'b01100, 5'd7)};
    vt[8] = '{"req_ready",     {5'd0, 5'd0}, 2'b00, 5'd0, 5'b00011, ex(5'b00000, 5'd0)};
    vt[9] = '{"all_zero",      {5'd0, 5'd0}, 2'b00, 5'd0, 5'b00000, ex(5'b00000, 5'd0)};

    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;
    cyc("in_reset", 11'd0);
    chk_cnt("cnt_reset", 16'd0);
    reset = 1'b0;
    cyc("after_reset", 11'd0);

    // One load-use stall, one branch and a three-cycle freeze.
    drive({5'd5, 5'd0}, 2'b10, 5'd5, 5'b11000); cyc("perf_lu",  ex(5'b10100, 5'd5));
    drive(10'd0, 2'b00, 5'd0, 5'b00100);        cyc("perf_br",  ex(5'b01100, 5'd0));
    drive(10'd0, 2'b00, 5'd0, 5'b00010);        cyc("perf_f1",  ex(5'b10010, 5'd0));
    cyc("perf_f2", ex(5'b10010, 5'd0));
    cyc("perf_f3", ex(5'b10010, 5'd0));
    drive(10'd0, 2'b00, 5'd0, 5'b00001);        cyc("perf_rel", ex(5'b00000, 5'd0));
    chk_cnt("cnt_perf", PERF_EXP);

    for (int i = 0; i < 10; i++) begin
      drive(vt[i].rs, vt[i].usr, vt[i].rd, vt[i].ctl);
      cyc(vt[i].nm, vt[i].e);
    end

    // Memory wait of three cycles; a load-use during the freeze must not bubble.
    drive(10'd0, 2'b00, 5'd0, 5'b00010);        cyc("mw_req",    ex(5'b10010, 5'd0));
    drive({5'd5, 5'd0}, 2'b10, 5'd5, 5'b11010); cyc("mw_lu_frz", ex(5'b10010, 5'd5));
    drive(10'd0, 2'b00, 5'd0, 5'b00010);        cyc("mw_wait",   ex(5'b10010, 5'd0));
    drive(10'd0, 2'b00, 5'd0, 5'b00011);        cyc("mw_done",   ex(5'b00000, 5'd0));
    idle();                                     cyc("mw_idle",   ex(5'b00000, 5'd0));

    // Branch during second frozen cycle is deferred to the first unfrozen cycle.
    drive(10'd0, 2'b00, 5'd0, 5'b00010);        cyc("df_req",    ex(5'b10010, 5'd0));
    drive(10'd0, 2'b00, 5'd0, 5'b00100);        cyc("df_br_frz", ex(5'b10010, 5'd0));
    drive(10'd0, 2'b00, 5'd0, 5'b00000);        cyc("df_frz",    ex(5'b10010, 5'd0));
    drive(10'd0, 2'b00, 5'd0, 5'b00001);        cyc("df_flush",  ex(5'b01100, 5'd0));
    idle();                                     cyc("df_clear",  ex(5'b00000, 5'd0));

    // TIMEOUT=4: flag appears after five wait cycles, freeze persists, flag is sticky.
    drive(10'd0, 2'b00, 5'd0, 5'b00010);        cyc("to_req",    ex(5'b10010, 5'd0));
    idle();
    for (int i = 1; i <= 5; i++) cyc($sformatf("to_wait%0d", i), ex(5'b10010, 5'd0));
    cyc("to_set", ex(5'b10011, 5'd0));
    drive(10'd0, 2'b00, 5'd0, 5'b00001);        cyc("to_rel",    ex(5'b00001, 5'd0));
    idle();                                     cyc("to_sticky", ex(5'b00001, 5'd0));

    // Reset in the middle of a wait.
    drive(10'd0, 2'b00, 5'd0, 5'b00010);        cyc("rw_req",    ex(5'b10011, 5'd0));
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc("rw_after", ex(5'b00000, 5'd0));
    chk_cnt("cnt_after_rst", 16'd0);
    cyc("rw_idle", ex(5'b00000, 5'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard and stall controller for the five-stage core. Sits upstream of the forwarding control in the decode/execute boundary. Handles three hazards:
- load-use hazards, by inserting one bubble into ID/EX;
- taken branches, by flushing IF/ID and ID/EX;
- data-memory wait states, by freezing the whole pipeline until `mem_ready`.

It also guarantees the forwarding logic never sees a stale destination register during a bubble or freeze.

## Interface
- `TIMEOUT`, default 255: max consecutive memory-wait cycles before `mem_timeout` is raised; 1..255.
- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2`  in  1 each  ID instruction actually reads rs1 / rs2.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_reg_write`  in  1  EX instruction writes `ex_rd`.
- `ex_is_load`  in  1  EX instruction is a load.
- `branch_taken`  in  1  EX resolved a taken branch/jump this cycle.
- `mem_req`  in  1  MEM stage issues a data-memory access this cycle.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `pc_stall`  out  1  hold PC.
- `ifid_stall`  out  1  hold IF/ID register.
- `ifid_flush`  out  1  load NOP into IF/ID.
- `idex_bubble`  out  1  load NOP (`rd`=0, no write) into ID/EX.
- `pipe_freeze`  out  1  hold ID/EX, EX/MEM, MEM/WB.
- `fwd_rd`  out  5  `ex_rd` qualified for forwarding: 0 when `ex_reg_write`=0.
- `mem_timeout`  out  1  sticky error flag.
- `stall_cycles`  out  16  performance counter (see Configuration).

## Operation
- FSM states: RUN, MEM_WAIT.
- RUN → MEM_WAIT when `mem_req`=1 and `mem_ready`=0.
- MEM_WAIT → RUN on the cycle `mem_ready`=1.
- `reset` → RUN from any state, including mid-wait.
- Freeze (combinational): `pipe_freeze` = `pc_stall` = `ifid_stall` = 1 while (RUN and `mem_req` and !`mem_ready`) or (MEM_WAIT and !`mem_ready`).
- While frozen, `ifid_flush` = `idex_bubble` = 0.
- Load-use: `lu` = `ex_is_load` & `ex_reg_write` & (`ex_rd`≠0) & ((`id_use_rs1` & `id_rs1`==`ex_rd`) | (`id_use_rs2` & `id_rs2`==`ex_rd`)).
- When `lu`=1, not frozen, and no flush is active: `pc_stall` = `ifid_stall` = `idex_bubble` = 1 for exactly one cycle. The bubble then occupies EX, so `lu` clears on its own.
- Branch flush: a flush is active when `branch_taken`=1 and not frozen, or `flush_pend`=1 and not frozen. A flush drives `ifid_flush` = `idex_bubble` = 1, and `pc_stall` = `ifid_stall` = 0.
- A flush overrides load-use, because the ID instruction is squashed.
- Deferred flush: if `branch_taken`=1 while frozen, set `flush_pend`. The flush is applied on the first non-frozen cycle, then `flush_pend` clears.
- Priority: reset > freeze > flush > load-use.
- Timeout: `wait_cnt` (8 bit) clears in RUN and increments each MEM_WAIT cycle, saturating at 255.
- `mem_timeout` is set when `wait_cnt`==`TIMEOUT` while still in MEM_WAIT. It stays set until `reset`.
- Reaching the timeout does not release the freeze.
- `fwd_rd` = `ex_reg_write` ? `ex_rd` : 0. Purely combinational.

## Timing
- All stall/flush/freeze outputs are combinational from current inputs and registered state. Zero-cycle latency: asserted in the same cycle the hazard is present.
- Registered state: FSM, `flush_pend`, `wait_cnt`, `mem_timeout`, `stall_cycles`.
- Reset values: FSM=RUN, `flush_pend`=0, `wait_cnt`=0, `mem_timeout`=0, `stall_cycles`=0.
- With all inputs 0, every output is 0 during and after reset.
- `mem_req`=1 with `mem_ready`=1 in the same cycle: no freeze, state stays RUN.
- Freeze length = number of cycles `mem_ready` is low after the request, including the request cycle.
- Load-use stall costs exactly 1 cycle. A taken branch costs 2 squashed instructions.

## Configuration
- `HAZARD_PERF_CNT_EN`.
- **Defined:** `stall_cycles` increments, saturating at 16'hFFFF, on every cycle where `pc_stall`=1 or `ifid_flush`=1. It clears on `reset`.
- **Undefined:** `stall_cycles` is tied to 0, with no counter logic.

## Test plan
- Load-use: EX load x5 (`ex_is_load`=1, `ex_reg_write`=1, `ex_rd`=5); ID reads rs1=5 with `id_use_rs1`=1 -> `pc_stall` = `ifid_stall` = `idex_bubble` = 1 for one cycle. Same case with `ex_rd`=0 or `id_use_rs1`=0 -> no stall.
- Branch: `branch_taken`=1 for one cycle -> `ifid_flush` = `idex_bubble` = 1 that cycle, `pc_stall`=0. Coincident `lu`=1 -> flush only.
- Memory wait: `mem_req`=1, `mem_ready` low for 3 cycles -> `pipe_freeze`=1 for 3 cycles, clears in the cycle `mem_ready`=1. With `mem_ready` high in the request cycle -> no freeze.
- Deferred flush: `branch_taken`=1 during the 2nd frozen cycle -> no flush while frozen; `ifid_flush`=1 exactly in the first unfrozen cycle.
- Timeout/reset: `TIMEOUT`=4, `mem_ready` held low -> `mem_timeout`=1 after 5 wait cycles and stays set. `reset` mid-wait -> FSM RUN, all outputs 0 in the next cycle.
- With `HAZARD_PERF_CNT_EN` defined: 1 load-use stall + 1 branch + a 3-cycle freeze -> `stall_cycles`=5.
